// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues one instruction-memory read
//               per instruction, holds the fetched word for decode, and picks
//               the next PC (sequential, conditional branch or jump) when
//               decode consumes the held instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [1:0]  branch_type_i,
  input  logic        zero_i,
  input  logic        neg_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] c_BEQ  = 2'd0;
  localparam logic [1:0] c_BGT  = 2'd1;
  localparam logic [1:0] c_BGEZ = 2'd2;
  localparam logic [1:0] c_BNE  = 2'd3;

  // The PC must stay word aligned even if the parameter is misconfigured.
  localparam logic [31:0] c_RESET_PC = RESET_PC & 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instrPc;
  logic [31:0] r_instrCnt;

  logic [31:0] w_pc4;
  logic [31:0] w_immShift;
  logic        w_cond;
  logic [31:0] w_nextPc;

  // Branch condition evaluated from the ALU flags of the held instruction.
  always_comb begin
    w_cond = 1'b0;
    case (branch_type_i)
      c_BEQ:   w_cond = zero_i;
      c_BGT:   w_cond = !zero_i && !neg_i;
      c_BGEZ:  w_cond = !neg_i;
      c_BNE:   w_cond = !zero_i;
      default: w_cond = 1'b0;
    endcase
  end

  // Next-PC selection; jump outranks a taken branch, all arithmetic wraps.
  always_comb begin
    w_pc4      = r_instrPc + 32'd4;
    w_immShift = imm_i << 2;
    w_nextPc   = w_pc4;
    if (jump_i) begin
      w_nextPc = {w_pc4[31:28], r_instr[25:0], 2'b00};
    end else if (branch_i && w_cond) begin
      w_nextPc = w_pc4 + w_immShift;
    end
  end

  // Fetch FSM: request, capture on ack, hold until decode takes the word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_pc       <= c_RESET_PC;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_instrPc  <= 32'd0;
      r_instrCnt <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
          r_valid <= 1'b0;
        end
        REQ: begin
          if (imem_ack_i) begin
            r_instr   <= imem_rdata_i;
            r_instrPc <= r_pc;
            r_state   <= HOLD;
            r_req     <= 1'b0;
            r_valid   <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready_i) begin
            r_pc       <= w_nextPc & 32'hFFFF_FFFC;
            r_instrCnt <= r_instrCnt + 32'd1;
            r_state    <= REQ;
            r_req      <= 1'b1;
            r_valid    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instrPc;
  assign instr_cnt_o   = r_instrCnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. The driver pushes expected
//               request addresses and fetched instructions into queues; a
//               monitor pops and compares on each accepted request and each
//               instruction handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_o;
  logic        branch_i;
  logic        jump_i;
  logic [1:0]  branch_type_i;
  logic        zero_i;
  logic        neg_i;
  logic [31:0] imm_i;
  logic [31:0] instr_cnt_o;

  int nVec = 0;
  int nBad = 0;
  logic [31:0] expCnt = 32'd0;

  logic [31:0] addrQ[$];
  logic [63:0] instrQ[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .pc_o         (pc_o),
    .branch_i     (branch_i),
    .jump_i       (jump_i),
    .branch_type_i(branch_type_i),
    .zero_i       (zero_i),
    .neg_i        (neg_i),
    .imm_i        (imm_i),
    .instr_cnt_o  (instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare accepted requests and handoffs against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      if (imem_req_o && imem_ack_i) begin
        if (addrQ.size() == 0) check("unexpectedReq", {32'd0, imem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("reqAddr", {32'd0, imem_addr_o}, {32'd0, addrQ.pop_front()});
      end
      if (instr_valid_o && instr_ready_i) begin
        if (instrQ.size() == 0) check("unexpectedHandoff", {instr_o, instr_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("handoffInstr", {instr_o, instr_pc_o}, instrQ.pop_front());
      end
    end
  end

  // One complete fetch: wait for the request, ack after `waits` idle cycles,
  // hold for `hold` cycles, then hand off with the given decode controls.
  task automatic fetchOne(input int waits, input logic [31:0] rdata, input logic [31:0] expAddr,
                          input int hold, input logic br, input logic jmp, input logic [1:0] bt,
                          input logic z, input logic n, input logic [31:0] imm,
                          input logic [31:0] nextAddr, input bit forceWrap);
    int guard;
    addrQ.push_back(expAddr);
    instrQ.push_back({rdata, expAddr});
    guard = 0;
    while (!imem_req_o && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (!imem_req_o) begin
      check("reqTimeout", 64'd0, 64'd1);
      return;
    end
    for (int w = 0; w < waits; w++) begin
      imem_ack_i = 1'b0;
      @(negedge clk_i);
      check("addrStable", {31'd0, imem_req_o, imem_addr_o}, {31'd0, 1'b1, expAddr});
      @(posedge clk_i); #1;
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = rdata;
    @(posedge clk_i); #1;
    for (int h = 0; h < hold; h++) begin
      // Stray acks with junk data while holding must be ignored.
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'hDEAD_BEEF ^ h;
      @(negedge clk_i);
      check("holdStable", {instr_o, instr_pc_o}, {rdata, expAddr});
      check("holdFlags", {62'd0, instr_valid_o, imem_req_o}, {62'd0, 2'b10});
      @(posedge clk_i); #1;
    end
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'hDEAD_BEEF;
    if (forceWrap) begin
      force dut.r_instrCnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_instrCnt;
      expCnt = 32'hFFFF_FFFF;
    end
    branch_i = br; jump_i = jmp; branch_type_i = bt; zero_i = z; neg_i = n; imm_i = imm;
    instr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    instr_ready_i = 1'b0;
    branch_i = 1'b0; jump_i = 1'b0; branch_type_i = 2'd0; zero_i = 1'b0; neg_i = 1'b0;
    imm_i = 32'h5555_5555;
    expCnt = expCnt + 32'd1;
    @(negedge clk_i);
    check("instrCnt", {32'd0, instr_cnt_o}, {32'd0, expCnt});
    check("nextReq", {30'd0, imem_req_o, instr_valid_o, imem_addr_o}, {30'd0, 2'b10, nextAddr});
  endtask

  initial begin
    int guard;
    rst_i = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = 32'd0; instr_ready_i = 1'b0;
    branch_i = 1'b0; jump_i = 1'b0; branch_type_i = 2'd0; zero_i = 1'b0; neg_i = 1'b0;
    imm_i = 32'd0;
    @(negedge clk_i);
    check("rstFlags", {62'd0, imem_req_o, instr_valid_o}, 64'd0);
    check("rstPc", {32'd0, pc_o}, 64'd0);
    check("rstInstr", {instr_o, instr_pc_o}, 64'd0);
    check("rstCnt", {32'd0, instr_cnt_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("idleNoReq", {63'd0, imem_req_o}, 64'd0);

    // Zero-wait fetch at reset PC, sequential successor.
    fetchOne(0, 32'h2008_0005, 32'h0000_0000, 2, 0, 0, 2'd0, 0, 0, 32'd0, 32'h0000_0004, 0);
    // Three wait cycles, long hold, jump to 0x40.
    fetchOne(3, 32'h0800_0010, 32'h0000_0004, 5, 0, 1, 2'd0, 0, 0, 32'd0, 32'h0000_0040, 0);
    // BEQ taken / not taken.
    fetchOne(0, 32'h1000_FFFE, 32'h0000_0040, 0, 1, 0, 2'd0, 1, 0, 32'hFFFF_FFFE, 32'h0000_003C, 0);
    fetchOne(0, 32'h1000_0001, 32'h0000_003C, 1, 1, 0, 2'd0, 0, 0, 32'hFFFF_FFFE, 32'h0000_0040, 0);
    // BNE taken / not taken.
    fetchOne(1, 32'h1400_FFFE, 32'h0000_0040, 0, 1, 0, 2'd3, 0, 1, 32'hFFFF_FFFE, 32'h0000_003C, 0);
    fetchOne(0, 32'h1400_0004, 32'h0000_003C, 0, 1, 0, 2'd3, 1, 0, 32'h0000_0004, 32'h0000_0040, 0);
    // BGT: taken, negative, zero.
    fetchOne(0, 32'h1C00_0002, 32'h0000_0040, 0, 1, 0, 2'd1, 0, 0, 32'h0000_0002, 32'h0000_004C, 0);
    fetchOne(0, 32'h1C00_0002, 32'h0000_004C, 0, 1, 0, 2'd1, 0, 1, 32'h0000_0002, 32'h0000_0050, 0);
    fetchOne(0, 32'h1C00_0002, 32'h0000_0050, 0, 1, 0, 2'd1, 1, 0, 32'h0000_0002, 32'h0000_0054, 0);
    // BGEZ: taken on zero, not taken on negative.
    fetchOne(0, 32'h0400_0003, 32'h0000_0054, 0, 1, 0, 2'd2, 1, 0, 32'h0000_0003, 32'h0000_0064, 0);
    fetchOne(0, 32'h0400_0003, 32'h0000_0064, 0, 1, 0, 2'd2, 0, 1, 32'h0000_0003, 32'h0000_0068, 0);
    // Far branch to 0x1000_0008, then jump+branch where jump wins.
    fetchOne(0, 32'h1000_0000, 32'h0000_0068, 0, 1, 0, 2'd0, 1, 0, 32'h03FF_FFE7, 32'h1000_0008, 0);
    fetchOne(2, 32'h0800_0100, 32'h1000_0008, 0, 1, 1, 2'd0, 1, 0, 32'hFFFF_FFFE, 32'h1000_0400, 0);
    // Branch to the top word, then sequential wrap to zero.
    fetchOne(0, 32'h0400_0000, 32'h1000_0400, 0, 1, 0, 2'd2, 0, 0, 32'h3BFF_FEFE, 32'hFFFF_FFFC, 0);
    fetchOne(0, 32'h0000_0020, 32'hFFFF_FFFC, 0, 0, 0, 2'd0, 0, 0, 32'd0, 32'h0000_0000, 0);
    // Instruction counter wrap from all-ones.
    fetchOne(0, 32'h0000_0021, 32'h0000_0000, 1, 0, 0, 2'd0, 0, 0, 32'd0, 32'h0000_0004, 1);
    fetchOne(1, 32'h0000_0022, 32'h0000_0004, 0, 0, 0, 2'd0, 0, 0, 32'd0, 32'h0000_0008, 0);

    // Reset mid-REQ at 0x8, with a late ack in the following IDLE cycle.
    guard = 0;
    while (!imem_req_o && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("preRstReq", {31'd0, imem_req_o, imem_addr_o}, {31'd0, 1'b1, 32'h0000_0008});
    #2;
    rst_i = 1'b0;
    #1;
    check("asyncRst", {30'd0, imem_req_o, instr_valid_o, pc_o}, 64'd0);
    check("asyncRstCnt", {instr_cnt_o, instr_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hBAD0_0BAD;
    @(negedge clk_i);
    check("lateAckIdle", {62'd0, imem_req_o, instr_valid_o}, 64'd0);
    @(posedge clk_i); #1;
    imem_ack_i = 1'b0;
    @(negedge clk_i);
    check("reissue", {30'd0, imem_req_o, instr_valid_o, imem_addr_o}, {30'd0, 2'b10, 32'd0});
    expCnt = 32'd0;
    fetchOne(0, 32'h2008_0005, 32'h0000_0000, 0, 0, 0, 2'd0, 0, 0, 32'd0, 32'h0000_0004, 0);

    repeat (2) @(posedge clk_i);
    check("scoreboardEmpty", {32'd0, 16'(addrQ.size()), 16'(instrQ.size())}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL globalTimeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
